// File: rtl/console_pkg.sv
// Shared constants, state encoding and the ASCII-to-glyph mapping for the text console writer.
package console_pkg;

    localparam logic [3:0] GLYPH_BLANK = 4'd15;
    localparam logic [3:0] GLYPH_UNK   = 4'd14;

    localparam logic [7:0] ASCII_BS    = 8'h08;
    localparam logic [7:0] ASCII_LF    = 8'h0A;
    localparam logic [7:0] ASCII_FF    = 8'h0C;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_SPACE = 8'h20;
    localparam logic [7:0] ASCII_TILDE = 8'h7E;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WRITE    = 2'd1,
        CLR_LINE = 2'd2,
        CLR_ALL  = 2'd3
    } console_state_t;

    function automatic logic is_printable(input logic [7:0] b);
        return (b >= ASCII_SPACE) && (b <= ASCII_TILDE);
    endfunction

    // Digits map straight to their value; the font only has a handful of symbols.
    function automatic logic [3:0] ascii_to_glyph(input logic [7:0] b);
        logic [3:0] g;
        if ((b >= 8'h30) && (b <= 8'h39)) begin
            g = b[3:0];
        end else begin
            case (b)
                8'h2B:       g = 4'd10;
                8'h2D:       g = 4'd11;
                8'h3A:       g = 4'd12;
                8'h3D:       g = 4'd13;
                ASCII_SPACE: g = GLYPH_BLANK;
                default:     g = GLYPH_UNK;
            endcase
        end
        return g;
    endfunction

endpackage

// File: rtl/text_console_writer_if.sv
// Byte-stream handshake from the CPU display data register into the console writer.
// A byte moves on a rising clk edge where char_valid and char_ready are both high;
// the producer holds char_data/char_valid stable until that edge, and char_ready
// never depends on char_valid.
interface text_console_writer_if;
    logic [7:0] char_data;
    logic       char_valid;
    logic       char_ready;

    modport master (output char_data, output char_valid, input char_ready);
    modport slave  (input char_data, input char_valid, output char_ready);
endinterface

// File: rtl/console_cursor.sv
// Cursor row/column counters plus a running row_base (row*COLS) kept by addition only.
module console_cursor
    import console_pkg::*;
#(
    parameter int COLS = 80,
    parameter int ROWS = 30
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        advance,
    input  logic        newline,
    input  logic        carriage,
    input  logic        backspace,
    input  logic        home,
    output logic [4:0]  row,
    output logic [6:0]  col,
    output logic [11:0] row_base,
    output logic        col_last,
    output logic        col_zero,
    output logic        row_last
);

    assign col_last = (col == 7'(COLS - 1));
    assign col_zero = (col == 7'd0);
    assign row_last = (row == 5'(ROWS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row      <= 5'd0;
            col      <= 7'd0;
            row_base <= 12'd0;
        end else if (home) begin
            row      <= 5'd0;
            col      <= 7'd0;
            row_base <= 12'd0;
        end else if (newline || (advance && col_last)) begin
            col <= 7'd0;
            // Scrolling is not supported: the bottom row wraps to the top.
            if (row_last) begin
                row      <= 5'd0;
                row_base <= 12'd0;
            end else begin
                row      <= row + 5'd1;
                row_base <= row_base + 12'(COLS);
            end
        end else if (advance) begin
            col <= col + 7'd1;
        end else if (carriage) begin
            col <= 7'd0;
        end else if (backspace && !col_zero) begin
            col <= col - 7'd1;
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// Converts a CPU ASCII byte stream into glyph writes for the text buffer, tracking the
// cursor and blanking lines / the whole screen one cell per cycle.
module text_console_writer
    import console_pkg::*;
#(
    parameter int COLS           = 80,
    parameter int ROWS           = 30,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    text_console_writer_if.slave  cpu,
    output logic [3:0]            new_char,
    output logic [11:0]           waddr,
    output logic                  text_en,
    output logic [4:0]            cursor_row,
    output logic [6:0]            cursor_col,
    output logic                  busy,
    output console_state_t        state_dbg
);

    localparam logic [11:0] LAST_CELL = 12'(COLS * ROWS - 1);
    localparam logic [6:0]  LAST_COL  = 7'(COLS - 1);

    console_state_t state, nxt_state;

    logic        started;
    logic        wrap_pending, nxt_wrap_pending;
    logic [6:0]  clr_cnt;
    logic        nxt_text_en;
    logic [11:0] nxt_waddr;
    logic [3:0]  nxt_new_char;

    logic        cur_advance, cur_newline, cur_carriage, cur_backspace, cur_home;
    logic [4:0]  row;
    logic [6:0]  col;
    logic [11:0] row_base;
    logic        col_last, col_zero, row_last;

    logic        accept;
    logic        is_print, is_lf, is_cr, is_bs, is_ff;
    logic [11:0] cur_addr, next_base;
    logic        clr_line_done, clr_all_done;

    console_cursor #(.COLS(COLS), .ROWS(ROWS)) u_cursor (
        .clk       (clk),
        .rst       (rst),
        .advance   (cur_advance),
        .newline   (cur_newline),
        .carriage  (cur_carriage),
        .backspace (cur_backspace),
        .home      (cur_home),
        .row       (row),
        .col       (col),
        .row_base  (row_base),
        .col_last  (col_last),
        .col_zero  (col_zero),
        .row_last  (row_last)
    );

    // started keeps char_ready low during reset and for the first cycle after it.
    assign cpu.char_ready = started && (state == IDLE);
    assign accept         = cpu.char_valid && cpu.char_ready;
    assign busy           = (state == CLR_LINE) || (state == CLR_ALL);
    assign cursor_row     = row;
    assign cursor_col     = col;
    assign state_dbg      = state;

    assign is_print = is_printable(cpu.char_data);
    assign is_lf    = (cpu.char_data == ASCII_LF);
    assign is_cr    = (cpu.char_data == ASCII_CR);
    assign is_bs    = (cpu.char_data == ASCII_BS);
    assign is_ff    = (cpu.char_data == ASCII_FF);

    assign cur_addr      = row_base + {5'd0, col};
    assign next_base     = row_last ? 12'd0 : (row_base + 12'(COLS));
    assign clr_line_done = (clr_cnt == LAST_COL);
    assign clr_all_done  = (waddr == LAST_CELL);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= nxt_state;
        end
    end

    always_comb begin
        nxt_state = state;
        case (state)
            IDLE: begin
                if (!started) begin
                    nxt_state = (CLEAR_ON_RESET != 0) ? CLR_ALL : IDLE;
                end else if (accept) begin
                    if (is_print || (is_bs && !col_zero)) begin
                        nxt_state = WRITE;
                    end else if (is_lf) begin
                        nxt_state = CLR_LINE;
                    end else if (is_ff) begin
                        nxt_state = CLR_ALL;
                    end
                end
            end
            WRITE:    nxt_state = wrap_pending ? CLR_LINE : IDLE;
            CLR_LINE: if (clr_line_done) nxt_state = IDLE;
            CLR_ALL:  if (clr_all_done) nxt_state = IDLE;
            default:  nxt_state = IDLE;
        endcase
    end

    // Output registers are loaded with the strobe for the state being entered, so each
    // strobe lines up with the cycle its state is visible on state_dbg/busy.
    always_comb begin
        nxt_text_en      = 1'b0;
        nxt_waddr        = waddr;
        nxt_new_char     = new_char;
        nxt_wrap_pending = 1'b0;
        cur_advance      = 1'b0;
        cur_newline      = 1'b0;
        cur_carriage     = 1'b0;
        cur_backspace    = 1'b0;
        cur_home         = 1'b0;
        case (state)
            IDLE: begin
                if (!started) begin
                    if (CLEAR_ON_RESET != 0) begin
                        nxt_text_en  = 1'b1;
                        nxt_waddr    = 12'd0;
                        nxt_new_char = GLYPH_BLANK;
                    end
                end else if (accept) begin
                    if (is_print) begin
                        nxt_text_en      = 1'b1;
                        nxt_waddr        = cur_addr;
                        nxt_new_char     = ascii_to_glyph(cpu.char_data);
                        nxt_wrap_pending = col_last;
                        cur_advance      = 1'b1;
                    end else if (is_bs && !col_zero) begin
                        nxt_text_en   = 1'b1;
                        nxt_waddr     = cur_addr - 12'd1;
                        nxt_new_char  = GLYPH_BLANK;
                        cur_backspace = 1'b1;
                    end else if (is_lf) begin
                        nxt_text_en  = 1'b1;
                        nxt_waddr    = next_base;
                        nxt_new_char = GLYPH_BLANK;
                        cur_newline  = 1'b1;
                    end else if (is_cr) begin
                        cur_carriage = 1'b1;
                    end else if (is_ff) begin
                        nxt_text_en  = 1'b1;
                        nxt_waddr    = 12'd0;
                        nxt_new_char = GLYPH_BLANK;
                    end
                end
            end
            WRITE: begin
                // Cursor already moved to the new row during the write cycle.
                if (wrap_pending) begin
                    nxt_text_en  = 1'b1;
                    nxt_waddr    = row_base;
                    nxt_new_char = GLYPH_BLANK;
                end
            end
            CLR_LINE: begin
                if (!clr_line_done) begin
                    nxt_text_en = 1'b1;
                    nxt_waddr   = waddr + 12'd1;
                end
            end
            CLR_ALL: begin
                if (!clr_all_done) begin
                    nxt_text_en = 1'b1;
                    nxt_waddr   = waddr + 12'd1;
                end else begin
                    cur_home = 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            text_en      <= 1'b0;
            waddr        <= 12'd0;
            new_char     <= GLYPH_BLANK;
            started      <= 1'b0;
            wrap_pending <= 1'b0;
            clr_cnt      <= 7'd0;
        end else begin
            text_en      <= nxt_text_en;
            waddr        <= nxt_waddr;
            new_char     <= nxt_new_char;
            started      <= 1'b1;
            wrap_pending <= nxt_wrap_pending;
            clr_cnt      <= (state == CLR_LINE) ? (clr_cnt + 7'd1) : 7'd0;
        end
    end

endmodule

// File: tb/tb_text_console_writer.sv
// Directed bench for text_console_writer: every expected write goes into exp_q and a
// negedge monitor pops and compares each strobe the DUT produces.
module tb_text_console_writer;
    import console_pkg::*;

    logic           clk;
    logic           rst;
    logic [3:0]     new_char;
    logic [11:0]    waddr;
    logic           text_en;
    logic [4:0]     cursor_row;
    logic [6:0]     cursor_col;
    logic           busy;
    console_state_t state_dbg;

    text_console_writer_if cif ();

    text_console_writer #(.COLS(80), .ROWS(30), .CLEAR_ON_RESET(1)) dut (
        .clk        (clk),
        .rst        (rst),
        .cpu        (cif),
        .new_char   (new_char),
        .waddr      (waddr),
        .text_en    (text_en),
        .cursor_row (cursor_row),
        .cursor_col (cursor_col),
        .busy       (busy),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- scoreboard ----------------
    logic [15:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int strobe_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push_write(input int addr, input logic [3:0] glyph);
        logic [11:0] a;
        a = 12'(addr);
        exp_q.push_back({a, glyph});
    endtask

    task automatic push_blanks(input int first, input int count);
        for (int i = 0; i < count; i++) push_write(first + i, GLYPH_BLANK);
    endtask

    always @(negedge clk) begin
        if (!rst && text_en) begin
            strobe_cnt++;
            check("ready_low_on_strobe", {31'd0, cif.char_ready}, 32'd0);
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_write: got addr=%0d glyph=%0d with empty queue", waddr, new_char);
            end else begin
                check("write", {16'd0, waddr, new_char}, {16'd0, exp_q.pop_front()});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send_byte(input logic [7:0] b);
        int n;
        n = 0;
        @(negedge clk);
        cif.char_data  = b;
        cif.char_valid = 1'b1;
        while (!cif.char_ready && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (!cif.char_ready) begin
            total++;
            bad++;
            $display("FAIL send_timeout: byte 0x%0h never accepted", b);
        end
        @(posedge clk);
        #1;
        cif.char_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (!(cif.char_ready && !busy) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) begin
            total++;
            bad++;
            $display("FAIL idle_timeout: ready=%0d busy=%0d", cif.char_ready, busy);
        end
    endtask

    task automatic check_cursor(input string name, input int r, input int c);
        check({name, "_row"}, {27'd0, cursor_row}, 32'(r));
        check({name, "_col"}, {25'd0, cursor_col}, 32'(c));
    endtask

    // Counts full-screen clear strobes until char_ready rises.
    task automatic run_full_clear(input string name);
        int n;
        int ready_bad;
        n = 0;
        ready_bad = 0;
        strobe_cnt = 0;
        @(negedge clk);
        while (!cif.char_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check({name, "_strobes"}, 32'(strobe_cnt), 32'd2400);
        check({name, "_ready"}, {31'd0, cif.char_ready}, 32'd1);
        check({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
        check_cursor(name, 0, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int busy_cycles;
        int n;
        logic [7:0] sym [5];
        logic [3:0] sym_g [5];

        cif.char_data  = 8'h00;
        cif.char_valid = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);

        // 1: reset values, then the power-up clear
        check("rst_text_en", {31'd0, text_en}, 32'd0);
        check("rst_new_char", {28'd0, new_char}, 32'd15);
        check("rst_waddr", {20'd0, waddr}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_ready", {31'd0, cif.char_ready}, 32'd0);
        check("rst_state", {30'd0, state_dbg}, {30'd0, IDLE});
        check_cursor("rst_cursor", 0, 0);
        push_blanks(0, 2400);
        rst = 1'b0;
        run_full_clear("init_clear");

        // 2: '7' at 0/0
        push_write(0, 4'd7);
        send_byte(8'h37);
        check("digit_ready_low", {31'd0, cif.char_ready}, 32'd0);
        check("digit_text_en", {31'd0, text_en}, 32'd1);
        check_cursor("digit_cursor", 0, 1);
        @(posedge clk);
        #1;
        check("digit_ready_back", {31'd0, cif.char_ready}, 32'd1);

        // CR: no write, ready stays high, column back to 0
        send_byte(ASCII_CR);
        check("cr_ready", {31'd0, cif.char_ready}, 32'd1);
        check_cursor("cr_cursor", 0, 0);

        // 3: 80 x 'A' then wrap clear of row 1
        for (int i = 0; i < 80; i++) push_write(i, GLYPH_UNK);
        push_blanks(80, 80);
        for (int i = 0; i < 80; i++) send_byte(8'h41);
        wait_idle();
        check("wrap_queue_left", 32'(exp_q.size()), 32'd0);
        check_cursor("wrap_cursor", 1, 0);

        // 4: walk to 29/5 with LFs and symbols, then LF wraps to row 0
        for (int r = 2; r < 30; r++) begin
            push_blanks(r * 80, 80);
            send_byte(ASCII_LF);
        end
        sym[0] = 8'h2B; sym_g[0] = 4'd10;
        sym[1] = 8'h2D; sym_g[1] = 4'd11;
        sym[2] = 8'h3A; sym_g[2] = 4'd12;
        sym[3] = 8'h3D; sym_g[3] = 4'd13;
        sym[4] = 8'h20; sym_g[4] = 4'd15;
        for (int i = 0; i < 5; i++) begin
            push_write(2320 + i, sym_g[i]);
            send_byte(sym[i]);
        end
        wait_idle();
        check_cursor("pre_lf_cursor", 29, 5);
        push_blanks(0, 80);
        send_byte(ASCII_LF);
        busy_cycles = 0;
        n = 0;
        @(negedge clk);
        while (busy && n < 500) begin
            busy_cycles++;
            n++;
            @(negedge clk);
        end
        check("lf_busy_cycles", 32'(busy_cycles), 32'd80);
        check("lf_queue_left", 32'(exp_q.size()), 32'd0);
        check_cursor("lf_cursor", 0, 0);

        // 5: backspace at column 0 and 3, ignored control and high bytes
        push_blanks(80, 80);
        send_byte(ASCII_LF);
        push_blanks(160, 80);
        send_byte(ASCII_LF);
        wait_idle();
        send_byte(ASCII_BS);
        check("bs0_ready", {31'd0, cif.char_ready}, 32'd1);
        check_cursor("bs0_cursor", 2, 0);
        push_write(160, 4'd1);
        send_byte(8'h31);
        push_write(161, 4'd2);
        send_byte(8'h32);
        push_write(162, 4'd3);
        send_byte(8'h33);
        wait_idle();
        check_cursor("digits_cursor", 2, 3);
        push_write(162, GLYPH_BLANK);
        send_byte(ASCII_BS);
        wait_idle();
        check_cursor("bs_cursor", 2, 2);
        send_byte(8'h07);
        send_byte(8'h80);
        send_byte(8'h7F);
        wait_idle();
        check_cursor("ignored_cursor", 2, 2);
        push_write(162, GLYPH_UNK);
        send_byte(8'h61);
        wait_idle();
        check_cursor("lower_cursor", 2, 3);
        check("bs_queue_left", 32'(exp_q.size()), 32'd0);

        // 6: FF, reset after 1000 strobes, clear restarts from 0
        push_blanks(0, 1000);
        strobe_cnt = 0;
        send_byte(ASCII_FF);
        n = 0;
        while (strobe_cnt < 1000 && n < 3000) begin
            @(posedge clk);
            #2;
            n++;
        end
        check("ff_strobes_before_rst", 32'(strobe_cnt), 32'd1000);
        rst = 1'b1;
        #1;
        check("midrst_text_en", {31'd0, text_en}, 32'd0);
        check("midrst_waddr", {20'd0, waddr}, 32'd0);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_queue_left", 32'(exp_q.size()), 32'd0);
        repeat (2) @(negedge clk);
        check("midrst_text_en_held", {31'd0, text_en}, 32'd0);
        push_blanks(0, 2400);
        rst = 1'b0;
        run_full_clear("restart_clear");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
